// File: rtl/henad_pipe_ctrl_pkg.sv
// Shared definitions for the Henad pipeline control unit: branch FSM encoding,
// default register-file geometry and a constant ceiling-log2 helper.
package henad_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_IDLE     = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_FLUSH    = 2'd2
  } pc_state_e;

  localparam int NREG_DEF   = 16;
  localparam int REG_AW_DEF = 4;

  function automatic int clog2_c(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/henad_sb_counter.sv
// Single-register in-flight write counter: saturating up/down, with an
// underflow flag raised when a retirement arrives for a register with no writes pending.
module henad_sb_counter
  import henad_pipe_ctrl_pkg::*;
#(
  parameter int MAX_CNT = 3,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  // A simultaneous issue and retire on the same register cancel out.
  always_comb underflow = dec & !inc & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc & !dec & (cnt != CNT_W'(MAX_CNT))) begin
      cnt <= cnt + 1'b1;
    end else if (dec & !inc & (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/henad_pipe_ctrl.sv
// Henad decode/issue control: per-register write scoreboard plus branch-redirect FSM.
// Optional write-through bypass of RAW hazards via `define HENAD_PIPE_WB_BYPASS_EN.
module henad_pipe_ctrl
  import henad_pipe_ctrl_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int NREG        = NREG_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MAX_INFL    = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic              issue_src1_en,
  input  logic [REG_AW-1:0] issue_src1,
  input  logic              issue_src2_en,
  input  logic [REG_AW-1:0] issue_src2,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [DATA_W-1:0] br_target,
  output logic              stall,
  output logic              flush,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic [NREG-1:0]   busy_mask,
  output logic              sb_err
);

  localparam int CNT_W = clog2_c(MAX_INFL + 1);
  localparam int BUB_W = 3;

  logic [CNT_W-1:0]  cnt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [NREG-1:0]   nz_vec;
  logic [NREG-1:0]   uflow_vec;

  pc_state_e         state;
  logic [BUB_W-1:0]  bub_cnt;
  logic [DATA_W-1:0] pc_target_q;
  logic              flush_q;
  logic              pc_load_q;
  logic              sb_err_q;

  logic              fire;
  logic              ready_int;
  logic              haz;
  logic              haz_s1;
  logic              haz_s2;
  logic              haz_waw;
  logic              byp_s1;
  logic              byp_s2;
  logic [CNT_W-1:0]  cnt_s1;
  logic [CNT_W-1:0]  cnt_s2;
  logic [CNT_W-1:0]  cnt_dst;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    assign inc_vec[gi] = fire & (issue_dst == REG_AW'(gi));
    assign dec_vec[gi] = wb_valid & (wb_dst == REG_AW'(gi));
    assign nz_vec[gi]  = (cnt[gi] != '0);

    henad_sb_counter #(
      .MAX_CNT (MAX_INFL),
      .CNT_W   (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[gi]),
      .dec       (dec_vec[gi]),
      .cnt       (cnt[gi]),
      .underflow (uflow_vec[gi])
    );
  end

  assign cnt_s1  = cnt[issue_src1];
  assign cnt_s2  = cnt[issue_src2];
  assign cnt_dst = cnt[issue_dst];

`ifdef HENAD_PIPE_WB_BYPASS_EN
  // The last pending write landing this cycle is visible through the register file.
  assign byp_s1 = (cnt_s1 == CNT_W'(1)) & wb_valid & (wb_dst == issue_src1);
  assign byp_s2 = (cnt_s2 == CNT_W'(1)) & wb_valid & (wb_dst == issue_src2);
`else
  assign byp_s1 = 1'b0;
  assign byp_s2 = 1'b0;
`endif

  assign haz_s1    = issue_src1_en & (cnt_s1 != '0) & !byp_s1;
  assign haz_s2    = issue_src2_en & (cnt_s2 != '0) & !byp_s2;
  assign haz_waw   = issue_we & (cnt_dst == CNT_W'(MAX_INFL));
  assign haz       = haz_s1 | haz_s2 | haz_waw;

  assign ready_int = !haz & (state == PC_IDLE);
  assign fire      = issue_valid & ready_int & issue_we;

  assign issue_ready = rst | ready_int;
  assign stall       = !rst & issue_valid & !ready_int;
  assign flush       = !rst & flush_q;
  assign pc_load     = !rst & pc_load_q;
  assign pc_target   = rst ? '0 : pc_target_q;
  assign busy_mask   = rst ? '0 : nz_vec;
  assign sb_err      = !rst & sb_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (|uflow_vec) begin
      sb_err_q <= 1'b1;
    end
  end

  // Branch redirect: one REDIRECT cycle, then FLUSH_DEPTH-1 further flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PC_IDLE;
      bub_cnt     <= '0;
      pc_target_q <= '0;
      flush_q     <= 1'b0;
      pc_load_q   <= 1'b0;
    end else begin
      case (state)
        PC_IDLE: begin
          if (br_valid & br_taken) begin
            pc_target_q <= br_target;
            state       <= PC_REDIRECT;
            pc_load_q   <= 1'b1;
            flush_q     <= 1'b1;
          end
        end
        PC_REDIRECT: begin
          bub_cnt   <= BUB_W'(FLUSH_DEPTH - 1);
          pc_load_q <= 1'b0;
          if (FLUSH_DEPTH > 1) begin
            state   <= PC_FLUSH;
            flush_q <= 1'b1;
          end else begin
            state   <= PC_IDLE;
            flush_q <= 1'b0;
          end
        end
        PC_FLUSH: begin
          if (bub_cnt <= BUB_W'(1)) begin
            bub_cnt <= '0;
            state   <= PC_IDLE;
            flush_q <= 1'b0;
          end else begin
            bub_cnt <= bub_cnt - 1'b1;
          end
        end
        default: begin
          state     <= PC_IDLE;
          flush_q   <= 1'b0;
          pc_load_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
